// File: rtl/seq_signbcd_converter_if.sv
// Start/busy/done handshake plus result bus of the sequential binary-to-BCD converter.
interface seq_signbcd_converter_if #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 3
);
   logic                  start;
   logic [WIDTH-1:0]      binary;
   logic                  busy;
   logic                  done;
   logic                  sign_b;
   logic [4*DIGITS-1:0]   bcd;
   logic                  overflow;

   // Requester side: issues conversions and observes results
   modport master (
      output start, binary,
      input  busy, done, sign_b, bcd, overflow
   );

   // Converter side
   modport slave (
      input  start, binary,
      output busy, done, sign_b, bcd, overflow
   );
endinterface

// File: rtl/seq_signbcd_converter.sv
// Iterative double-dabble converter: one input bit per clock, optional two's-complement input.
module seq_signbcd_converter #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 3,
   parameter bit          SIGNED = 1'b1
) (
   input logic                    clk,
   input logic                    rst,
   seq_signbcd_converter_if.slave bus
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(WIDTH);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   mag_q, mag_d;
   logic [BCD_W-1:0]   scratch_q, scratch_d;
   logic [BCD_W-1:0]   adj;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_acc_q, ovf_acc_d;
   logic               sign_pend_q, sign_pend_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               sign_b_q, sign_b_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic               overflow_q, overflow_d;

   // Add-3 correction of every scratch digit that is 5 or more, ahead of the shift
   always_comb begin
      adj = scratch_q;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      mag_d       = mag_q;
      scratch_d   = scratch_q;
      cnt_d       = cnt_q;
      ovf_acc_d   = ovf_acc_q;
      sign_pend_d = sign_pend_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      sign_b_d    = sign_b_q;
      bcd_d       = bcd_q;
      overflow_d  = overflow_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               // A negative input has a nonzero MSB, so negative zero never arises
               if (SIGNED && bus.binary[WIDTH-1]) begin
                  mag_d       = ~bus.binary + WIDTH'(1);
                  sign_pend_d = 1'b1;
               end else begin
                  mag_d       = bus.binary;
                  sign_pend_d = 1'b0;
               end
               scratch_d = '0;
               ovf_acc_d = 1'b0;
               cnt_d     = CNT_W'(WIDTH - 1);
               busy_d    = 1'b1;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            scratch_d = {adj[BCD_W-2:0], mag_q[WIDTH-1]};
            mag_d     = {mag_q[WIDTH-2:0], 1'b0};
            ovf_acc_d = ovf_acc_q | adj[BCD_W-1];
            cnt_d     = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
               bcd_d      = {adj[BCD_W-2:0], mag_q[WIDTH-1]};
               sign_b_d   = sign_pend_q;
               overflow_d = ovf_acc_q | adj[BCD_W-1];
               done_d     = 1'b1;
               busy_d     = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset drops any partial conversion
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mag_q       <= '0;
         scratch_q   <= '0;
         cnt_q       <= '0;
         ovf_acc_q   <= 1'b0;
         sign_pend_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         sign_b_q    <= 1'b0;
         bcd_q       <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         mag_q       <= mag_d;
         scratch_q   <= scratch_d;
         cnt_q       <= cnt_d;
         ovf_acc_q   <= ovf_acc_d;
         sign_pend_q <= sign_pend_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         sign_b_q    <= sign_b_d;
         bcd_q       <= bcd_d;
         overflow_q  <= overflow_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.sign_b   = sign_b_q;
   assign bus.bcd      = bcd_q;
   assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_seq_signbcd_converter.sv
// Bench for seq_signbcd_converter across four parameter sets, scoreboard-checked on done.
module tb_seq_signbcd_converter;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   typedef struct packed {
      logic        sign;
      logic [19:0] bcd;
      logic        ovf;
   } exp_t;

   exp_t q0[$], q1[$], q2[$], q3[$];
   int   dones0 = 0;

   seq_signbcd_converter_if #(.WIDTH(8),  .DIGITS(3)) if0();
   seq_signbcd_converter_if #(.WIDTH(8),  .DIGITS(3)) if1();
   seq_signbcd_converter_if #(.WIDTH(8),  .DIGITS(2)) if2();
   seq_signbcd_converter_if #(.WIDTH(16), .DIGITS(5)) if3();

   seq_signbcd_converter #(.WIDTH(8),  .DIGITS(3), .SIGNED(1'b1)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
   seq_signbcd_converter #(.WIDTH(8),  .DIGITS(3), .SIGNED(1'b0)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
   seq_signbcd_converter #(.WIDTH(8),  .DIGITS(2), .SIGNED(1'b0)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
   seq_signbcd_converter #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b1)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));

   // Reference: integer magnitude, decimal digits by repeated division
   function automatic exp_t model(int w, int d, bit s, logic [15:0] v);
      exp_t   e;
      longint mag;
      e   = '0;
      mag = longint'(v) & ((longint'(1) << w) - 1);
      if (s && v[w-1]) begin
         e.sign = 1'b1;
         mag    = (longint'(1) << w) - mag;
      end
      for (int i = 0; i < d; i++) begin
         e.bcd[4*i +: 4] = 4'(mag % 10);
         mag = mag / 10;
      end
      e.ovf = (mag != 0);
      return e;
   endfunction

   // Scoreboard pops, one monitor per instance
   always @(negedge clk) begin
      exp_t e, g;
      if (!rst && if0.done === 1'b1) begin
         dones0++;
         checks++;
         g = {if0.sign_b, 20'(if0.bcd), if0.overflow};
         if (q0.size() == 0) begin
            errors++;
            $display("FAIL u0_unexpected_done got=%h expected no done", g);
         end else begin
            e = q0.pop_front();
            if (g !== e) begin
               errors++;
               $display("FAIL u0_result got=%h expected=%h", g, e);
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e, g;
      if (!rst && if1.done === 1'b1) begin
         checks++;
         g = {if1.sign_b, 20'(if1.bcd), if1.overflow};
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL u1_unexpected_done got=%h expected no done", g);
         end else begin
            e = q1.pop_front();
            if (g !== e) begin
               errors++;
               $display("FAIL u1_result got=%h expected=%h", g, e);
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e, g;
      if (!rst && if2.done === 1'b1) begin
         checks++;
         g = {if2.sign_b, 20'(if2.bcd), if2.overflow};
         if (q2.size() == 0) begin
            errors++;
            $display("FAIL u2_unexpected_done got=%h expected no done", g);
         end else begin
            e = q2.pop_front();
            if (g !== e) begin
               errors++;
               $display("FAIL u2_result got=%h expected=%h", g, e);
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e, g;
      if (!rst && if3.done === 1'b1) begin
         checks++;
         g = {if3.sign_b, 20'(if3.bcd), if3.overflow};
         if (q3.size() == 0) begin
            errors++;
            $display("FAIL u3_unexpected_done got=%h expected no done", g);
         end else begin
            e = q3.pop_front();
            if (g !== e) begin
               errors++;
               $display("FAIL u3_result got=%h expected=%h", g, e);
            end
         end
      end
   end

   // Issue one conversion; returns at the negedge after the accepting edge
   task automatic go0(input logic [7:0] v);
      if0.binary = v; if0.start = 1'b1;
      q0.push_back(model(8, 3, 1'b1, 16'(v)));
      @(negedge clk);
      if0.start = 1'b0; if0.binary = 8'($urandom);
   endtask

   task automatic go1(input logic [7:0] v);
      if1.binary = v; if1.start = 1'b1;
      q1.push_back(model(8, 3, 1'b0, 16'(v)));
      @(negedge clk);
      if1.start = 1'b0; if1.binary = 8'($urandom);
   endtask

   task automatic go2(input logic [7:0] v);
      if2.binary = v; if2.start = 1'b1;
      q2.push_back(model(8, 2, 1'b0, 16'(v)));
      @(negedge clk);
      if2.start = 1'b0; if2.binary = 8'($urandom);
   endtask

   task automatic go3(input logic [15:0] v);
      if3.binary = v; if3.start = 1'b1;
      q3.push_back(model(16, 5, 1'b1, v));
      @(negedge clk);
      if3.start = 1'b0; if3.binary = 16'($urandom);
   endtask

   // Wait (bounded) for done on the selected instance; n = negedges waited
   task automatic wait_done(input int which, output int n);
      logic d;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         case (which)
            0:       d = if0.done;
            1:       d = if1.done;
            2:       d = if2.done;
            default: d = if3.done;
         endcase
      end while (d !== 1'b1 && n < 100);
      if (d !== 1'b1) begin
         checks++; errors++;
         $display("FAIL u%0d_done_timeout got=no done expected=done within 100 cycles", which);
      end
   endtask

   task automatic check_latency(input string name, input int n);
      checks++;
      if (n !== 8) begin
         errors++;
         $display("FAIL %s got=%0d expected=8", name, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      if0.start = 1'b0; if0.binary = '0;
      if1.start = 1'b0; if1.binary = '0;
      if2.start = 1'b0; if2.binary = '0;
      if3.start = 1'b0; if3.binary = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({if0.busy, if0.done, if0.sign_b, if0.bcd, if0.overflow} !== 16'h0) begin
         errors++;
         $display("FAIL reset_u0 got=%h expected=0", {if0.busy, if0.done, if0.sign_b, if0.bcd, if0.overflow});
      end
      checks++;
      if ({if3.busy, if3.done, if3.sign_b, if3.bcd, if3.overflow} !== 24'h0) begin
         errors++;
         $display("FAIL reset_u3 got=%h expected=0", {if3.busy, if3.done, if3.sign_b, if3.bcd, if3.overflow});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Most negative input; busy must be high for exactly WIDTH cycles
   task automatic test_min_negative();
      int nb;
      go0(8'h80);
      nb = 0;
      while (if0.busy === 1'b1 && nb < 50) begin
         nb++;
         @(negedge clk);
      end
      checks++;
      if (nb !== 8) begin
         errors++;
         $display("FAIL busy_cycles got=%0d expected=8", nb);
      end
      checks++;
      if (if0.done !== 1'b1) begin
         errors++;
         $display("FAIL done_after_busy got=%b expected=1", if0.done);
      end
      repeat (2) @(negedge clk);
   endtask

   // Starts issued in each done cycle; previous result holds while busy
   task automatic test_back_to_back();
      int n;
      logic [7:0] vals[3];
      vals = '{8'h7F, 8'hFF, 8'h00};
      go0(vals[0]);
      checks++;
      if ({if0.sign_b, if0.bcd} !== 13'h1128) begin
         errors++;
         $display("FAIL hold_while_busy got=%h expected=1128", {if0.sign_b, if0.bcd});
      end
      for (int i = 1; i < 3; i++) begin
         wait_done(0, n);
         check_latency("b2b_latency", n);
         go0(vals[i]);
      end
      wait_done(0, n);
      check_latency("b2b_latency_last", n);
      for (int i = 0; i < 6; i++) begin
         go0(8'($urandom));
         wait_done(0, n);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_unsigned();
      int n;
      logic [7:0] vals[3];
      vals = '{8'hFF, 8'h00, 8'd100};
      for (int i = 0; i < 3; i++) begin
         go1(vals[i]);
         wait_done(1, n);
      end
   endtask

   task automatic test_overflow();
      int n;
      logic [7:0] vals[4];
      vals = '{8'd200, 8'd99, 8'd100, 8'd255};
      for (int i = 0; i < 4; i++) begin
         go2(vals[i]);
         wait_done(2, n);
      end
   endtask

   // start while busy must be ignored
   task automatic test_start_while_busy();
      int n, d0;
      d0 = dones0;
      go0(8'h9C);
      repeat (2) @(negedge clk);
      if0.binary = 8'h05; if0.start = 1'b1;
      @(negedge clk);
      if0.start = 1'b0;
      wait_done(0, n);
      repeat (10) @(negedge clk);
      checks++;
      if (dones0 - d0 !== 1) begin
         errors++;
         $display("FAIL ignored_start_dones got=%0d expected=1", dones0 - d0);
      end
   endtask

   // Reset mid-conversion discards it; a fresh conversion then works
   task automatic test_reset_mid();
      int n, d0;
      go0(8'hC8);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({if0.busy, if0.done, if0.sign_b, if0.bcd, if0.overflow} !== 16'h0) begin
         errors++;
         $display("FAIL reset_mid got=%h expected=0", {if0.busy, if0.done, if0.sign_b, if0.bcd, if0.overflow});
      end
      rst = 1'b0;
      q0.delete();
      d0 = dones0;
      repeat (12) @(negedge clk);
      checks++;
      if (dones0 !== d0) begin
         errors++;
         $display("FAIL reset_no_done got=%0d expected=%0d", dones0, d0);
      end
      go0(8'h85);
      wait_done(0, n);
      check_latency("post_reset_latency", n);
   endtask

   task automatic test_wide();
      int n;
      go3(16'h8000);
      wait_done(3, n);
      go3(16'h7FFF);
      wait_done(3, n);
      for (int i = 0; i < 4; i++) begin
         go3(16'($urandom));
         wait_done(3, n);
      end
   endtask

   task automatic test_drain();
      checks++;
      if (q0.size() + q1.size() + q2.size() + q3.size() !== 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d expected=0", q0.size() + q1.size() + q2.size() + q3.size());
      end
   endtask

   initial begin
      test_reset();
      test_min_negative();
      test_back_to_back();
      test_unsigned();
      test_overflow();
      test_start_while_busy();
      test_reset_mid();
      test_wide();
      repeat (3) @(negedge clk);
      test_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
